// File: rtl/dual_dmem_arbiter.sv
// Single-ported shared data memory for two MIPS cores with round-robin arbitration.
// Optional ARB_STATS_EN compiles in the saturating contested-cycle counter.
module dual_dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_stall,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_stall,
  output logic [15:0] conflict_cnt
);

  logic [31:0]   mem_q [DEPTH];
  logic          prio_q;
  logic [AW-1:0] a_idx, b_idx;
  logic          contested, gnt_a, gnt_b;

  assign a_idx     = a_addr[AW+1:2];
  assign b_idx     = b_addr[AW+1:2];
  assign contested = a_req & b_req;
  // Reset masks every grant so nothing is read, stalled or written during it.
  assign gnt_a     = ~rst & a_req & (~b_req | ~prio_q);
  assign gnt_b     = ~rst & b_req & (~a_req |  prio_q);

  assign a_stall = ~rst & contested &  prio_q;
  assign b_stall = ~rst & contested & ~prio_q;
  assign a_rdata = gnt_a ? mem_q[a_idx] : 32'h0;
  assign b_rdata = gnt_b ? mem_q[b_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      prio_q <= 1'b0;
    end else begin
      if (gnt_a && a_we)      mem_q[a_idx] <= a_wdata;
      else if (gnt_b && b_we) mem_q[b_idx] <= b_wdata;
      if (contested) prio_q <= ~prio_q;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (contested && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 16'h0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dual_dmem_arbiter.sv
// Directed table-driven bench for dual_dmem_arbiter; expectations follow ARB_STATS_EN.
module tb_dual_dmem_arbiter;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_stall, b_stall;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  dual_dmem_arbiter #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_stall(a_stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_stall(b_stall),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic        rst;
    logic        ar, aw;
    logic [31:0] aa, ad;
    logic        br, bw;
    logic [31:0] ba, bd;
    logic [1:0]  rmask;   // [1] check a_rdata, [0] check b_rdata
    logic [31:0] ea, eb;
    logic        sa, sb;
    logic [15:0] ec;      // counter value with stats enabled, before this cycle's edge
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic ar, input logic aw, input logic [31:0] aa,
                     input logic [31:0] ad, input logic br, input logic bw,
                     input logic [31:0] ba, input logic [31:0] bd, input logic [1:0] rm,
                     input logic [31:0] ea, input logic [31:0] eb, input logic sa,
                     input logic sb, input logic [15:0] ec);
    vec_t v;
    v = '{r, ar, aw, aa, ad, br, bw, ba, bd, rm, ea, eb, sa, sb, ec};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ar, input logic aw, input logic [31:0] aa,
                       input logic [31:0] ad, input logic br, input logic bw,
                       input logic [31:0] ba, input logic [31:0] bd);
    rst = r; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    //  rst ar aw aa            ad            br bw ba            bd            rm ea            eb            sa sb cnt
    add(1, 1, 0, 32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        3, 32'h0,        32'h0,        0, 0, 0);
    add(0, 1, 1, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0, 0, 0);
    add(0, 1, 0, 32'h10,       32'h0,        0, 0, 32'h0,        32'h0,        3, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    add(0, 1, 0, 32'h10,       32'h0,        1, 0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 32'h0,        0, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h10,       32'h0,        3, 32'h0,        32'hDEADBEEF, 0, 0, 1);
    // sustained contention: grants alternate and no stall repeats
    add(0, 1, 0, 32'h10,       32'h0,        1, 0, 32'h10,       32'h0,        3, 32'h0,        32'hDEADBEEF, 1, 0, 1);
    add(0, 1, 0, 32'h10,       32'h0,        1, 0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 32'h0,        0, 1, 2);
    add(0, 1, 0, 32'h10,       32'h0,        1, 0, 32'h10,       32'h0,        3, 32'h0,        32'hDEADBEEF, 1, 0, 3);
    add(0, 1, 0, 32'h10,       32'h0,        1, 0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 32'h0,        0, 1, 4);
    // same address, B has priority: B reads old value, A's write lands next cycle
    add(0, 1, 1, 32'h40,       32'h1234,     1, 0, 32'h40,       32'h0,        1, 32'h0,        32'h0,        1, 0, 5);
    add(0, 1, 1, 32'h40,       32'h1234,     0, 0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0, 0, 6);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h40,       32'h0,        3, 32'h0,        32'h1234,     0, 0, 6);
    // same address, A has priority: B sees A's write after its stall
    add(0, 1, 1, 32'h40,       32'h5678,     1, 0, 32'h40,       32'h0,        1, 32'h0,        32'h0,        0, 1, 6);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h40,       32'h0,        3, 32'h0,        32'h5678,     0, 0, 7);
    // address wrap and ignored address bits
    add(0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h100,      32'hCAFEF00D, 2, 32'h0,        32'h0,        0, 0, 7);
    add(0, 1, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        3, 32'hCAFEF00D, 32'h0,        0, 0, 7);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0, 32'hABCD0013, 32'h0,        3, 32'h0,        32'hDEADBEEF, 0, 0, 7);
    add(0, 1, 0, 32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        3, 32'h0,        32'hCAFEF00D, 1, 0, 7);
    add(0, 1, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        3, 32'hCAFEF00D, 32'h0,        0, 0, 8);
    // reset lands while A writes and B would be stalled
    add(1, 1, 1, 32'h10,       32'h11111111, 1, 0, 32'h10,       32'h0,        3, 32'h0,        32'h0,        0, 0, 8);
    add(0, 1, 0, 32'h10,       32'h0,        1, 0, 32'h10,       32'h0,        3, 32'h0,        32'h0,        0, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h10,       32'h0,        3, 32'h0,        32'h0,        0, 0, 1);

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.ar, v.aw, v.aa, v.ad, v.br, v.bw, v.ba, v.bd);
      #1;
      if (v.rmask[1]) chk($sformatf("v%0d a_rdata", i), a_rdata, v.ea);
      if (v.rmask[0]) chk($sformatf("v%0d b_rdata", i), b_rdata, v.eb);
      chk($sformatf("v%0d a_stall", i), {31'h0, a_stall}, {31'h0, v.sa});
      chk($sformatf("v%0d b_stall", i), {31'h0, b_stall}, {31'h0, v.sb});
      chk($sformatf("v%0d conflict_cnt", i), {16'h0, conflict_cnt}, {16'h0, STATS ? v.ec : 16'h0});
      @(negedge clk);
    end

    // whole array must read zero after the mid-contention reset
    for (int w = 0; w < 64; w++) begin
      drive(0, 1, 0, w << 2, 32'h0, 0, 0, 0, 0);
      #1;
      chk($sformatf("sweep[%0d] a_rdata", w), a_rdata, 32'h0);
      @(negedge clk);
    end

    // saturation: hammer contention well past 0xFFFF cycles
    begin
      int n;
      n = STATS ? 65540 : 8;
      for (int c = 0; c < n; c++) begin
        drive(0, 1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
        @(negedge clk);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("saturated conflict_cnt", {16'h0, conflict_cnt}, {16'h0, STATS ? 16'hFFFF : 16'h0});
      @(negedge clk);
      #1;
      chk("held conflict_cnt", {16'h0, conflict_cnt}, {16'h0, STATS ? 16'hFFFF : 16'h0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
